// File: rtl/alu_issue_ctrl.sv
// Issue controller for an external combinational 32-bit ALU: reads operands from a
// local register file, captures result/flags, writes back and returns a response.
module alu_issue_ctrl #(
  parameter int NREGS = 8,
  parameter int IMM_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [2:0]               in_op,
  input  logic [$clog2(NREGS)-1:0] in_rd,
  input  logic [$clog2(NREGS)-1:0] in_rs1,
  input  logic [$clog2(NREGS)-1:0] in_rs2,
  input  logic                     in_use_imm,
  input  logic [IMM_W-1:0]         in_imm,
  output logic [31:0]              alu_a,
  output logic [31:0]              alu_b,
  output logic [2:0]               alu_op,
  input  logic [31:0]              alu_result,
  input  logic                     alu_c,
  input  logic                     alu_v,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_result,
  output logic [3:0]               out_flags,
  input  logic                     hw_en,
  input  logic [$clog2(NREGS)-1:0] hw_addr,
  input  logic [31:0]              hw_data
);

  localparam int AW = $clog2(NREGS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_OPRD,
    S_EXEC,
    S_RESP
  } state_t;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;

  state_t             state_q;
  logic [2:0]         op_q;
  logic [AW-1:0]      rd_q;
  logic [AW-1:0]      rs1_q;
  logic [AW-1:0]      rs2_q;
  logic               use_imm_q;
  logic [IMM_W-1:0]   imm_q;
  logic [31:0]        alu_a_q;
  logic [31:0]        alu_b_q;
  logic [2:0]         alu_op_q;
  logic [31:0]        out_result_q;
  logic               out_valid_q;
  logic [3:0]         flags_q;
  logic [3:0]         flags_d;
  logic [31:0]        regs_q [NREGS];

  logic [31:0]        rs1_val;
  logic [31:0]        opb_val;
  logic [31:0]        imm_sext;
  logic               wb_en;
  logic               host_en;
  logic               arith_op;

  // r0 is never written, so reading it always yields the reset value of zero.
  assign rs1_val  = regs_q[rs1_q];
  assign imm_sext = 32'($signed(imm_q));
  assign opb_val  = use_imm_q ? imm_sext : regs_q[rs2_q];

  assign wb_en    = (state_q == S_EXEC) && (rd_q != '0);
  assign host_en  = (state_q == S_IDLE) && hw_en && (hw_addr != '0);
  assign arith_op = (op_q == OP_ADD) || (op_q == OP_SUB);

  // C and V belong to ADD/SUB only; logic and shift ops keep the previous pair.
  always_comb begin
    flags_d    = flags_q;
    flags_d[3] = alu_result[31];
    flags_d[2] = (alu_result == 32'd0);
    if (arith_op) begin
      flags_d[1] = alu_c;
      flags_d[0] = alu_v;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      op_q         <= '0;
      rd_q         <= '0;
      rs1_q        <= '0;
      rs2_q        <= '0;
      use_imm_q    <= 1'b0;
      imm_q        <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= '0;
      out_result_q <= '0;
      out_valid_q  <= 1'b0;
      flags_q      <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            op_q      <= in_op;
            rd_q      <= in_rd;
            rs1_q     <= in_rs1;
            rs2_q     <= in_rs2;
            use_imm_q <= in_use_imm;
            imm_q     <= in_imm;
            state_q   <= S_OPRD;
          end
        end
        S_OPRD: begin
          alu_a_q  <= rs1_val;
          alu_b_q  <= opb_val;
          alu_op_q <= op_q;
          state_q  <= S_EXEC;
        end
        S_EXEC: begin
          out_result_q <= alu_result;
          flags_q      <= flags_d;
          out_valid_q  <= 1'b1;
          state_q      <= S_RESP;
        end
        S_RESP: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Host preload and writeback live in disjoint states, so they never collide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      if (wb_en) begin
        regs_q[rd_q] <= alu_result;
      end
      if (host_en) begin
        regs_q[hw_addr] <= hw_data;
      end
    end
  end

  assign in_ready   = (state_q == S_IDLE);
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_op     = alu_op_q;
  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_flags  = flags_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: provides a bit-level ALU and checks responses against
// an arithmetic reference model of the register file and NZCV flags.
module tb_alu_issue_ctrl;

  localparam int CLK_P = 10;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [2:0]  in_rd, in_rs1, in_rs2;
  logic        in_use_imm;
  logic [15:0] in_imm;
  logic [31:0] alu_a, alu_b;
  logic [2:0]  alu_op;
  logic [31:0] alu_result;
  logic        alu_c, alu_v;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [3:0]  out_flags;
  logic        hw_en;
  logic [2:0]  hw_addr;
  logic [31:0] hw_data;
  logic        junk_c, junk_v;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_regs [8];
  logic        m_n, m_z, m_c, m_v;

  localparam longint MAXS = 64'sd2147483647;
  localparam longint MINS = -64'sd2147483648;

  always #(CLK_P/2) clk = ~clk;

  alu_issue_ctrl #(.NREGS(8), .IMM_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_use_imm(in_use_imm), .in_imm(in_imm),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_c(alu_c), .alu_v(alu_v),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_flags(out_flags),
    .hw_en(hw_en), .hw_addr(hw_addr), .hw_data(hw_data)
  );

  // External ALU; C/V for non-arithmetic ops are random junk the DUT must ignore.
  always_comb begin
    alu_result = 32'd0;
    alu_c      = junk_c;
    alu_v      = junk_v;
    case (alu_op)
      3'b000: begin
        {alu_c, alu_result} = {1'b0, alu_a} + {1'b0, alu_b};
        alu_v = (alu_a[31] == alu_b[31]) && (alu_result[31] != alu_a[31]);
      end
      3'b001: begin
        {alu_c, alu_result} = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;
        alu_v = (alu_a[31] != alu_b[31]) && (alu_result[31] != alu_a[31]);
      end
      3'b010: alu_result = alu_a & alu_b;
      3'b011: alu_result = alu_a | alu_b;
      3'b100: alu_result = alu_a ^ alu_b;
      3'b101: alu_result = alu_a << alu_b[4:0];
      3'b110: alu_result = alu_a >> alu_b[4:0];
      default: alu_result = $unsigned($signed(alu_a) >>> alu_b[4:0]);
    endcase
  end

  initial begin
    #(CLK_P * 100000);
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1, "watchdog");
  end

  function automatic void m_reset();
    for (int i = 0; i < 8; i++) m_regs[i] = 32'd0;
    {m_n, m_z, m_c, m_v} = 4'b0000;
  endfunction

  function automatic void m_host(input logic [2:0] a, input logic [31:0] d);
    if (a != 3'd0) m_regs[a] = d;
  endfunction

  // Reference semantics from plain integer arithmetic.
  function automatic void m_exec(input logic [2:0] op, input logic [2:0] rd,
                                 input logic [2:0] rs1, input logic [2:0] rs2,
                                 input logic use_imm, input logic [15:0] imm,
                                 output logic [31:0] r, output logic [3:0] f);
    logic [31:0] a, b;
    longint sa, sb, sr, ua, ub;
    a  = m_regs[rs1];
    b  = use_imm ? 32'($signed(imm)) : m_regs[rs2];
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    case (op)
      3'd0: begin
        r = a + b; sr = sa + sb;
        m_c = (ua + ub) > 64'sh0000_0000_FFFF_FFFF;
        m_v = (sr > MAXS) || (sr < MINS);
      end
      3'd1: begin
        r = a - b; sr = sa - sb;
        m_c = (a >= b);
        m_v = (sr > MAXS) || (sr < MINS);
      end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = a << b[4:0];
      3'd6: r = a >> b[4:0];
      default: r = $unsigned($signed(a) >>> b[4:0]);
    endcase
    m_n = r[31];
    m_z = (r == 32'd0);
    if (rd != 3'd0) m_regs[rd] = r;
    f = {m_n, m_z, m_c, m_v};
  endfunction

  // Called right after a falling edge; returns right after a falling edge.
  task automatic host_write(input logic [2:0] a, input logic [31:0] d);
    hw_en = 1'b1; hw_addr = a; hw_data = d;
    @(posedge clk);
    #1 hw_en = 1'b0;
    m_host(a, d);
    @(negedge clk);
  endtask

  // Issues one instruction with out_ready high; lat counts falling-edge samples
  // after the accept edge until out_valid is seen.
  task automatic run_instr(input logic [2:0] op, input logic [2:0] rd,
                           input logic [2:0] rs1, input logic [2:0] rs2,
                           input logic use_imm, input logic [15:0] imm,
                           input logic hw_w, input logic [2:0] hw_a, input logic [31:0] hw_d,
                           output logic [31:0] res, output logic [3:0] fl, output int lat,
                           output logic ov_after, output time t_acc, output logic timeout);
    int n;
    timeout = 1'b0; res = '0; fl = '0; lat = 0; ov_after = 1'b1; t_acc = 0;
    in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_use_imm = use_imm; in_imm = imm; in_valid = 1'b1; out_ready = 1'b1;
    hw_en = hw_w; hw_addr = hw_a; hw_data = hw_d;
    junk_c = 1'($urandom_range(0, 1)); junk_v = 1'($urandom_range(0, 1));
    n = 0;
    while (!in_ready && n < 20) begin @(negedge clk); n++; end
    if (!in_ready) begin
      timeout = 1'b1; in_valid = 1'b0; hw_en = 1'b0;
      return;
    end
    @(posedge clk);
    t_acc = $time;
    #1 in_valid = 1'b0; hw_en = 1'b0;
    do begin @(negedge clk); lat++; end while (!out_valid && lat < 12);
    if (!out_valid) begin timeout = 1'b1; return; end
    res = out_result;
    fl  = out_flags;
    @(negedge clk);
    ov_after = out_valid;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; hw_en = 1'b0;
    in_op = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_use_imm = 1'b0; in_imm = '0;
    hw_addr = '0; hw_data = '0; junk_c = 1'b0; junk_v = 1'b0;
    m_reset();
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_hs: in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
    end
    checks++;
    if (out_flags !== 4'b0000 || out_result !== 32'd0) begin
      errors++;
      $display("FAIL reset_out: flags=%b result=%h required 0000/0", out_flags, out_result);
    end
    checks++;
    if (alu_a !== 32'd0 || alu_b !== 32'd0 || alu_op !== 3'd0) begin
      errors++;
      $display("FAIL reset_alu: a=%h b=%h op=%0d required zeros", alu_a, alu_b, alu_op);
    end
  endtask

  task automatic test_reset_mid_exec();
    logic [31:0] r; logic [3:0] f; int lat; logic ova, to; time ta;
    host_write(3'd1, 32'h0000_0055);
    in_op = 3'd0; in_rd = 3'd3; in_rs1 = 3'd1; in_rs2 = 3'd1; in_use_imm = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_flags !== 4'b0000 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_exec: out_valid=%b flags=%b in_ready=%b required 0/0000/1",
               out_valid, out_flags, in_ready);
    end
    @(posedge clk);
    #2 rst_n = 1'b1;
    m_reset();
    @(negedge clk);
    run_instr(3'd0, 3'd2, 3'd1, 3'd0, 1'b0, 16'd0, 1'b0, 3'd0, 32'd0, r, f, lat, ova, ta, to);
    checks++;
    if (to || r !== 32'd0 || f !== 4'b0100) begin
      errors++;
      $display("FAIL post_reset_add: result=%h flags=%b timeout=%b required 0/0100", r, f, to);
    end
  endtask

  task automatic test_arith_flags();
    logic [31:0] r, er; logic [3:0] f, ef; int lat; logic ova, to; time ta;
    host_write(3'd1, 32'h7FFF_FFFF);
    host_write(3'd2, 32'h0000_0001);
    run_instr(3'd0, 3'd3, 3'd1, 3'd2, 1'b0, 16'd0, 1'b0, 3'd0, 32'd0, r, f, lat, ova, ta, to);
    m_exec(3'd0, 3'd3, 3'd1, 3'd2, 1'b0, 16'd0, er, ef);
    checks++;
    if (to || r !== 32'h8000_0000 || f !== 4'b1001) begin
      errors++;
      $display("FAIL add_ovf: result=%h flags=%b required 80000000/1001", r, f);
    end
    checks++;
    if (lat != 3 || ova !== 1'b0) begin
      errors++;
      $display("FAIL latency: samples=%0d drop=%b required 3/0", lat, ova);
    end
    run_instr(3'd4, 3'd4, 3'd3, 3'd3, 1'b0, 16'd0, 1'b0, 3'd0, 32'd0, r, f, lat, ova, ta, to);
    m_exec(3'd4, 3'd4, 3'd3, 3'd3, 1'b0, 16'd0, er, ef);
    checks++;
    if (to || r !== 32'd0 || f !== 4'b0101) begin
      errors++;
      $display("FAIL xor_hold_cv: result=%h flags=%b required 0/0101", r, f);
    end
    run_instr(3'd1, 3'd5, 3'd0, 3'd0, 1'b1, 16'h0001, 1'b0, 3'd0, 32'd0, r, f, lat, ova, ta, to);
    m_exec(3'd1, 3'd5, 3'd0, 3'd0, 1'b1, 16'h0001, er, ef);
    checks++;
    if (to || r !== 32'hFFFF_FFFF || f !== 4'b1000) begin
      errors++;
      $display("FAIL sub_imm: result=%h flags=%b required ffffffff/1000", r, f);
    end
    run_instr(3'd7, 3'd6, 3'd5, 3'd0, 1'b1, 16'h0004, 1'b0, 3'd0, 32'd0, r, f, lat, ova, ta, to);
    m_exec(3'd7, 3'd6, 3'd5, 3'd0, 1'b1, 16'h0004, er, ef);
    checks++;
    if (to || r !== 32'hFFFF_FFFF || f !== 4'b1000) begin
      errors++;
      $display("FAIL sra_imm: result=%h flags=%b required ffffffff/1000", r, f);
    end
  endtask

  task automatic test_r0_write();
    logic [31:0] r, er; logic [3:0] f, ef; int lat; logic ova, to; time ta;
    run_instr(3'd0, 3'd0, 3'd1, 3'd2, 1'b0, 16'd0, 1'b0, 3'd0, 32'd0, r, f, lat, ova, ta, to);
    m_exec(3'd0, 3'd0, 3'd1, 3'd2, 1'b0, 16'd0, er, ef);
    checks++;
    if (to || r !== 32'h8000_0000) begin
      errors++;
      $display("FAIL r0_result: result=%h required 80000000", r);
    end
    run_instr(3'd3, 3'd7, 3'd0, 3'd0, 1'b0, 16'd0, 1'b0, 3'd0, 32'd0, r, f, lat, ova, ta, to);
    m_exec(3'd3, 3'd7, 3'd0, 3'd0, 1'b0, 16'd0, er, ef);
    checks++;
    if (to || r !== 32'd0 || f !== 4'b0101) begin
      errors++;
      $display("FAIL r0_zero: result=%h flags=%b required 0/0101", r, f);
    end
  endtask

  task automatic test_host_write();
    logic [31:0] r, er; logic [3:0] f, ef; int lat, n; logic ova, to; time ta;
    m_host(3'd1, 32'h1234_5678);
    run_instr(3'd0, 3'd4, 3'd1, 3'd0, 1'b0, 16'd0, 1'b1, 3'd1, 32'h1234_5678,
              r, f, lat, ova, ta, to);
    m_exec(3'd0, 3'd4, 3'd1, 3'd0, 1'b0, 16'd0, er, ef);
    checks++;
    if (to || r !== 32'h1234_5678 || f !== ef) begin
      errors++;
      $display("FAIL host_same_cycle: result=%h flags=%b required %h/%b", r, f, er, ef);
    end
    host_write(3'd0, 32'h0000_FFFF);
    run_instr(3'd3, 3'd5, 3'd0, 3'd0, 1'b0, 16'd0, 1'b0, 3'd0, 32'd0, r, f, lat, ova, ta, to);
    m_exec(3'd3, 3'd5, 3'd0, 3'd0, 1'b0, 16'd0, er, ef);
    checks++;
    if (to || r !== 32'd0) begin
      errors++;
      $display("FAIL host_r0: result=%h required 0", r);
    end
    // Host strobe held through OPRD/EXEC/RESP must be ignored.
    in_op = 3'd3; in_rd = 3'd7; in_rs1 = 3'd0; in_rs2 = 3'd0; in_use_imm = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0; hw_en = 1'b1; hw_addr = 3'd2; hw_data = 32'hDEAD_BEEF;
    n = 0;
    do begin @(negedge clk); n++; end while (!out_valid && n < 12);
    @(posedge clk);
    #1 hw_en = 1'b0;
    @(negedge clk);
    m_exec(3'd3, 3'd7, 3'd0, 3'd0, 1'b0, 16'd0, er, ef);
    run_instr(3'd0, 3'd6, 3'd2, 3'd0, 1'b0, 16'd0, 1'b0, 3'd0, 32'd0, r, f, lat, ova, ta, to);
    m_exec(3'd0, 3'd6, 3'd2, 3'd0, 1'b0, 16'd0, er, ef);
    checks++;
    if (to || r !== er) begin
      errors++;
      $display("FAIL host_busy_ignored: result=%h required %h", r, er);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] held, er; logic [3:0] ef; int n;
    in_op = 3'd0; in_rd = 3'd5; in_rs1 = 3'd1; in_rs2 = 3'd2; in_use_imm = 1'b0;
    in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    #1 in_op = 3'd1; in_rd = 3'd6; in_rs1 = 3'd5; in_rs2 = 3'd1;
    m_exec(3'd0, 3'd5, 3'd1, 3'd2, 1'b0, 16'd0, er, ef);
    n = 0;
    do begin @(negedge clk); n++; end while (!out_valid && n < 12);
    held = out_result;
    checks++;
    if (out_valid !== 1'b1 || held !== er || out_flags !== ef) begin
      errors++;
      $display("FAIL bp_first: valid=%b result=%h flags=%b required 1/%h/%b",
               out_valid, held, out_flags, er, ef);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_result !== held || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_stall%0d: valid=%b result=%h in_ready=%b required 1/%h/0",
                 i, out_valid, out_result, in_ready, held);
      end
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: valid=%b in_ready=%b required 0/1", out_valid, in_ready);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    m_exec(3'd1, 3'd6, 3'd5, 3'd1, 1'b0, 16'd0, er, ef);
    n = 0;
    do begin @(negedge clk); n++; end while (!out_valid && n < 12);
    checks++;
    if (n != 3 || out_result !== er || out_flags !== ef) begin
      errors++;
      $display("FAIL bp_second: samples=%0d result=%h flags=%b required 3/%h/%b",
               n, out_result, out_flags, er, ef);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [31:0] r, er; logic [3:0] f, ef; int lat; logic ova, to; time ta, prev;
    logic [2:0] op, rd, s1, s2;
    prev = 0;
    for (int i = 0; i < 4; i++) begin
      op = 3'($urandom); rd = 3'($urandom); s1 = 3'($urandom); s2 = 3'($urandom);
      run_instr(op, rd, s1, s2, 1'b0, 16'd0, 1'b0, 3'd0, 32'd0, r, f, lat, ova, ta, to);
      m_exec(op, rd, s1, s2, 1'b0, 16'd0, er, ef);
      checks++;
      if (to || r !== er || f !== ef) begin
        errors++;
        $display("FAIL b2b%0d: result=%h flags=%b required %h/%b", i, r, f, er, ef);
      end
      if (i > 0) begin
        checks++;
        if (ta - prev != 4 * CLK_P) begin
          errors++;
          $display("FAIL b2b_spacing%0d: gap=%0t required %0d", i, ta - prev, 4 * CLK_P);
        end
      end
      prev = ta;
    end
  endtask

  task automatic test_random();
    logic [31:0] r, er, d; logic [3:0] f, ef; int lat; logic ova, to; time ta;
    logic [2:0] op, rd, s1, s2, a; logic ui; logic [15:0] imm;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        a = 3'($urandom); d = $urandom;
        host_write(a, d);
      end
      op = 3'($urandom); rd = 3'($urandom); s1 = 3'($urandom); s2 = 3'($urandom);
      ui = 1'($urandom); imm = 16'($urandom);
      run_instr(op, rd, s1, s2, ui, imm, 1'b0, 3'd0, 32'd0, r, f, lat, ova, ta, to);
      m_exec(op, rd, s1, s2, ui, imm, er, ef);
      checks++;
      if (to || r !== er || f !== ef || lat != 3 || ova !== 1'b0) begin
        errors++;
        $display("FAIL rand%0d op=%0d rd=%0d rs1=%0d rs2=%0d imm=%b/%h: result=%h flags=%b lat=%0d required %h/%b/3",
                 i, op, rd, s1, s2, ui, imm, r, f, lat, er, ef);
      end
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid_exec();
    test_arith_flags();
    test_r0_write();
    test_host_write();
    test_backpressure();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
